// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM writer slice.
//   SCR_BANK_LO / SCR_BANK_HI : 128K banks that hold the two screens
//   VRAM_AW                   : width of the shadow VRAM address space
//   region_e                  : decode of CPU addr[15:14]
//   vram_entry_t              : one queued write {waddr, data}
package vram_pkg;
   localparam logic [2:0] SCR_BANK_LO = 3'd5;
   localparam logic [2:0] SCR_BANK_HI = 3'd7;
   localparam int         VRAM_AW     = 15;

   typedef enum logic [1:0] {
      REG_ROM = 2'b00,   // 0x0000-0x3FFF
      REG_SCR = 2'b01,   // 0x4000-0x7FFF, always bank 5
      REG_MID = 2'b10,   // 0x8000-0xBFFF, bank 2
      REG_TOP = 2'b11    // 0xC000-0xFFFF, paged
   } region_e;

   typedef struct packed {
      logic [VRAM_AW-1:0] waddr;
      logic [7:0]         data;
   } vram_entry_t;
endpackage

// File: rtl/vram_writer_if.sv
// CPU snoop bus plus VRAM write port of the VRAM writer.
//   master : drives CPU bus, paging, vram_slot, clr_ovf (system side)
//   slave  : the writer; drives vram_we/waddr/wdata, fifo_level, overflow
interface vram_writer_if #(parameter int LVL_W = 3);
   logic [15:0]      addr;
   logic [7:0]       dout;
   logic             nMREQ;
   logic             nWR;
   logic             nRFSH;
   logic             m128;
   logic [2:0]       page_ram;
   logic             vram_slot;
   logic             clr_ovf;
   logic             vram_we;
   logic [14:0]      vram_waddr;
   logic [7:0]       vram_wdata;
   logic [LVL_W-1:0] fifo_level;
   logic             overflow;

   modport master (
      output addr, dout, nMREQ, nWR, nRFSH, m128, page_ram, vram_slot, clr_ovf,
      input  vram_we, vram_waddr, vram_wdata, fifo_level, overflow
   );
   modport slave (
      input  addr, dout, nMREQ, nWR, nRFSH, m128, page_ram, vram_slot, clr_ovf,
      output vram_we, vram_waddr, vram_wdata, fifo_level, overflow
   );
endinterface

// File: rtl/vram_wfifo.sv
// Synchronous FIFO of VRAM write entries.
//   push/pop : enqueue din / dequeue head at the clock edge
//   head     : current oldest entry (valid when !empty)
//   full, empty, level : occupancy, level in 0..DEPTH
// The caller must not push when full unless it pops in the same cycle.
module vram_wfifo
   import vram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic             clk_sys,
   input  logic             nRESET,
   input  logic             push,
   input  logic             pop,
   input  vram_entry_t      din,
   output vram_entry_t      head,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   vram_entry_t   mem [DEPTH];
   logic [PW-1:0] wptr, rptr;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: pointers define what is valid.
   always_ff @(posedge clk_sys) begin
      if (push) mem[wptr] <= din;
   end

   assign head  = mem[rptr];
   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);
endmodule

// File: rtl/vram_writer.sv
// Snoops Z80 writes, keeps those landing in screen bank 5/7, queues them
// and drains them into the shadow VRAM write port on free ULA slots.
//   clk_sys, nRESET : clock, async active-low reset
//   bus (slave)     : CPU snoop inputs, paging, vram_slot, clr_ovf in;
//                     vram_we/waddr/wdata, fifo_level, overflow out
module vram_writer
   import vram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input logic           clk_sys,
   input logic           nRESET,
   vram_writer_if.slave  bus
);
   logic               wstrobe, wstrobe_q, new_wr;
   logic               hit, push, pop, drop;
   logic               full, empty;
   logic [VRAM_AW-1:0] map_addr;
   region_e            region;
   vram_entry_t        head, din;

   assign wstrobe = ~bus.nMREQ & ~bus.nWR & bus.nRFSH;
   assign new_wr  = wstrobe & ~wstrobe_q;

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) wstrobe_q <= 1'b0;
      else         wstrobe_q <= wstrobe;
   end

   // Bank decode at the strobe edge; later paging changes do not touch
   // entries already queued.
   always_comb begin
      hit      = 1'b0;
      map_addr = {1'b0, bus.addr[13:0]};
      region   = region_e'(bus.addr[15:14]);
      if (new_wr) begin
         case (region)
            REG_SCR: hit = 1'b1;
            REG_TOP: begin
               if (bus.m128 && bus.page_ram == SCR_BANK_LO) begin
                  hit = 1'b1;
               end else if (bus.m128 && bus.page_ram == SCR_BANK_HI) begin
                  hit         = 1'b1;
                  map_addr[14] = 1'b1;
               end
            end
            default: hit = 1'b0;
         endcase
      end
   end

   // No bypass: pop only sees what was queued before this edge.
   assign pop  = bus.vram_slot & ~empty;
   assign push = hit & (~full | pop);
   assign drop = hit & full & ~pop;
   assign din  = '{waddr: map_addr, data: bus.dout};

   vram_wfifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
      .clk_sys (clk_sys),
      .nRESET  (nRESET),
      .push    (push),
      .pop     (pop),
      .din     (din),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .level   (bus.fifo_level)
   );

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         bus.vram_we    <= 1'b0;
         bus.vram_waddr <= '0;
         bus.vram_wdata <= '0;
         bus.overflow   <= 1'b0;
      end else begin
         bus.vram_we <= pop;
         if (pop) begin
            bus.vram_waddr <= head.waddr;
            bus.vram_wdata <= head.data;
         end
         // A drop in the same cycle as clr_ovf keeps the flag set.
         if (drop)             bus.overflow <= 1'b1;
         else if (bus.clr_ovf) bus.overflow <= 1'b0;
      end
   end
endmodule
